// File: rtl/bus_pkg.sv
// bus_pkg: shared width defaults and FSM encoding for master_out_port.
package bus_pkg;
  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BURST_WIDTH = 13;
  localparam int ADDR_CYCLES     = 12;
  typedef enum logic [2:0] {
    IDLE, WAIT_HANDSHAKE, ADDR_SEND, BURST_GAP, DATA_SEND, DONE
  } state_t;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load serial-out shifter, LSB first, zero fill.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] r_sr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sr <= '0;
    else if (load) r_sr <= din;
    else if (shift) r_sr <= {1'b0, r_sr[WIDTH-1:1]};
  assign sout = r_sr[0];
endmodule

// File: rtl/master_out_port.sv
// master_out_port: serial bus master sending address/burst/data fields LSB first.
// Multi-beat write bursts are enabled with `define MASTER_OUT_BURST_EN.
module master_out_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [ADDR_WIDTH-1:0]  in_address,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [BURST_WIDTH-1:0] in_burst,
  input  logic                   slave_ready,
  output logic                   tx_address,
  output logic                   tx_data,
  output logic                   tx_burst,
  output logic                   master_valid,
  output logic                   read_en,
  output logic                   write_en,
  output logic                   data_req,
  output logic                   tx_busy,
  output logic                   tx_done
);
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_mode;
  logic w_load, w_shift, w_more, w_active, w_burst_sout;
  logic [BURST_WIDTH-1:0] w_burst_din;
`ifdef MASTER_OUT_BURST_EN
  logic [BURST_WIDTH-1:0] r_beats;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_beats <= '0;
    else if (w_load) r_beats <= in_burst;
    else if (r_state == BURST_GAP) r_beats <= r_beats - BURST_WIDTH'(1);
  assign w_more      = |r_beats[BURST_WIDTH-1:1];
  assign w_burst_din = in_burst;
  assign tx_burst    = w_burst_sout;
  assign data_req    = r_state == BURST_GAP;
`else
  logic w_unused;
  assign w_unused    = ^{in_burst, w_burst_sout};
  assign w_more      = 1'b0;
  assign w_burst_din = '0;
  assign tx_burst    = 1'b0;
  assign data_req    = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           w_next = start ? WAIT_HANDSHAKE : IDLE;
      WAIT_HANDSHAKE: w_next = slave_ready ? ADDR_SEND : WAIT_HANDSHAKE;
      ADDR_SEND:      if (r_cnt == 4'(ADDR_CYCLES - 1)) w_next = (r_mode && w_more) ? BURST_GAP : DONE;
      BURST_GAP:      w_next = DATA_SEND;
      DATA_SEND:      if (r_cnt == 4'(DATA_WIDTH - 1)) w_next = w_more ? BURST_GAP : DONE;
      default:        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && (r_state == ADDR_SEND || r_state == DATA_SEND)) ? r_cnt + 4'd1 : '0;
      if (w_load) r_mode <= mode;
    end
  assign w_load  = r_state == IDLE && start;
  assign w_shift = (r_state == WAIT_HANDSHAKE && slave_ready) || r_state == ADDR_SEND || r_state == DATA_SEND;
  piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(clk), .reset(reset), .load(w_load), .shift(w_shift),
    .din(in_address), .sout(tx_address)
  );
  // Read transactions load zeros so tx_data stays low for the whole transfer.
  piso_shift #(.WIDTH(DATA_WIDTH)) u_data (
    .clk(clk), .reset(reset), .load(w_load || r_state == BURST_GAP), .shift(w_shift),
    .din((mode || r_state == BURST_GAP) ? in_data : '0), .sout(tx_data)
  );
  piso_shift #(.WIDTH(BURST_WIDTH)) u_burst (
    .clk(clk), .reset(reset), .load(w_load), .shift(w_shift),
    .din(w_burst_din), .sout(w_burst_sout)
  );
  assign w_active     = r_state != IDLE && r_state != DONE;
  assign master_valid = r_state == WAIT_HANDSHAKE;
  assign read_en      = w_active && !r_mode;
  assign write_en     = w_active && r_mode;
  assign tx_busy      = r_state != IDLE;
  assign tx_done      = r_state == DONE;
endmodule

// File: tb/tb_master_out_port.sv
// tb_master_out_port: directed vector table plus reset-abort sequence for master_out_port.
module tb_master_out_port;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, slave_ready = 1'b0;
  logic [11:0] in_address = '0;
  logic [7:0] in_data = '0;
  logic [12:0] in_burst = '0;
  logic tx_address, tx_data, tx_burst, master_valid, read_en, write_en, data_req, tx_busy, tx_done;
  int n_chk = 0, n_bad = 0;
  typedef struct {
    logic mode; logic [11:0] addr; logic [12:0] burst; int delay;
    logic [7:0] b0, b1, b2;
    logic [12:0] e_addr; logic [63:0] e_data; logic [12:0] e_burst; int e_done; int e_dreq;
  } vec_t;
  vec_t v[6];
  master_out_port dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .in_address(in_address),
    .in_data(in_data), .in_burst(in_burst), .slave_ready(slave_ready),
    .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
    .master_valid(master_valid), .read_en(read_en), .write_en(write_en),
    .data_req(data_req), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int id, input vec_t t);
    logic [7:0] bytes[3];
    logic [12:0] cap_a, cap_b;
    logic [63:0] cap_d;
    logic hold_ok, prev;
    logic [1:0] rw;
    int idx, cyc, done_at, dreqs;
    bytes[0] = t.b0; bytes[1] = t.b1; bytes[2] = t.b2;
    start = 1'b1; mode = t.mode; in_address = t.addr; in_data = t.b0; in_burst = t.burst;
    slave_ready = (t.delay == 0);
    step();
    start = 1'b0; in_data = t.b1; idx = 1;
    hold_ok = 1'b1;
    for (int d = 0; d < t.delay; d++) begin
      if (!(master_valid && tx_address == t.addr[0] && tx_busy)) hold_ok = 1'b0;
      step();
    end
    chk($sformatf("v%0d hold", id), 64'(hold_ok), 64'd1);
    chk($sformatf("v%0d valid", id), 64'(master_valid), 64'd1);
    slave_ready = 1'b1;
    cap_a = '0; cap_b = '0; cap_d = '0; cyc = 0; done_at = -1; dreqs = 0; rw = '0;
    while (cyc < 64 && done_at < 0) begin
      if (cyc == 0) rw = {read_en, write_en};
      if (tx_done) done_at = cyc;
      else begin
        if (cyc < 13) begin
          cap_a[cyc] = tx_address;
          cap_b[cyc] = tx_burst;
        end
        cap_d[cyc] = tx_data;
        dreqs += int'(data_req);
      end
      prev = data_req;
      if (cyc == 3) start = 1'b1;
      step();
      start = 1'b0;
      if (prev && idx < 2) begin
        idx++;
        in_data = bytes[idx];
      end
      cyc++;
    end
    chk($sformatf("v%0d rw", id), 64'(rw), {62'd0, !t.mode, t.mode});
    chk($sformatf("v%0d done_at", id), 64'(done_at), 64'(t.e_done));
    chk($sformatf("v%0d addr", id), 64'(cap_a), 64'(t.e_addr));
    chk($sformatf("v%0d burst", id), 64'(cap_b), 64'(t.e_burst));
    chk($sformatf("v%0d data", id), cap_d, t.e_data);
    chk($sformatf("v%0d dreq", id), 64'(dreqs), 64'(t.e_dreq));
    chk($sformatf("v%0d idle", id), 64'({tx_busy, read_en, write_en, master_valid}), 64'd0);
    slave_ready = 1'b0;
  endtask
  initial begin
    logic saw_done;
`ifdef MASTER_OUT_BURST_EN
    v[0] = '{1'b1, 12'hA5C, 13'd0, 0, 8'h3B, 8'h00, 8'h00, 13'hA5C, 64'h3B, 13'd0, 13, 0};
    v[1] = '{1'b0, 12'h123, 13'd0, 0, 8'hFF, 8'h00, 8'h00, 13'h123, 64'h0, 13'd0, 13, 0};
    v[2] = '{1'b1, 12'h801, 13'd1, 5, 8'h80, 8'h00, 8'h00, 13'h801, 64'h80, 13'd1, 13, 0};
    v[3] = '{1'b1, 12'h456, 13'd3, 0, 8'h11, 8'h22, 8'h33, 13'h456,
             (64'h33 << 23) | (64'h22 << 14) | 64'h11, 13'd3, 31, 2};
    v[4] = '{1'b0, 12'hFFF, 13'd5, 1, 8'hA5, 8'h00, 8'h00, 13'hFFF, 64'h0, 13'd5, 13, 0};
    v[5] = '{1'b1, 12'h0F0, 13'd2, 2, 8'hAA, 8'h55, 8'h00, 13'h0F0,
             (64'h55 << 14) | 64'hAA, 13'd2, 22, 1};
`else
    v[0] = '{1'b1, 12'hA5C, 13'd0, 0, 8'h3B, 8'h00, 8'h00, 13'hA5C, 64'h3B, 13'd0, 13, 0};
    v[1] = '{1'b0, 12'h123, 13'd0, 0, 8'hFF, 8'h00, 8'h00, 13'h123, 64'h0, 13'd0, 13, 0};
    v[2] = '{1'b1, 12'h801, 13'd1, 5, 8'h80, 8'h00, 8'h00, 13'h801, 64'h80, 13'd0, 13, 0};
    v[3] = '{1'b1, 12'h456, 13'd3, 0, 8'h11, 8'h22, 8'h33, 13'h456, 64'h11, 13'd0, 13, 0};
    v[4] = '{1'b0, 12'hFFF, 13'd5, 1, 8'hA5, 8'h00, 8'h00, 13'hFFF, 64'h0, 13'd0, 13, 0};
    v[5] = '{1'b1, 12'h0F0, 13'd2, 2, 8'hAA, 8'h55, 8'h00, 13'h0F0, 64'hAA, 13'd0, 13, 0};
`endif
    #1;
    chk("reset outputs", 64'({master_valid, read_en, write_en, data_req, tx_busy, tx_done,
                              tx_address, tx_data, tx_burst}), 64'd0);
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 6; i++) run(i, v[i]);
    start = 1'b1; mode = 1'b1; in_address = 12'hFFF; in_data = 8'hFF; in_burst = 13'd0;
    slave_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre-abort busy", 64'({tx_busy, write_en}), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("abort outputs", 64'({master_valid, read_en, write_en, data_req, tx_busy, tx_done,
                              tx_address, tx_data, tx_burst}), 64'd0);
    saw_done = 1'b0;
    repeat (3) begin
      step();
      saw_done |= tx_done | tx_busy;
    end
    chk("abort no done", 64'(saw_done), 64'd0);
    reset = 1'b1;
    slave_ready = 1'b0;
    step();
    run(6, v[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 Parameters: ADDR_WIDTH, default 12, address bits. DATA_WIDTH, default 8, data bits. BURST_WIDTH, default 13, burst-length bits.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle transaction request, sampled in IDLE only.
REQ-005 mode  input  1  1=write, 0=read; latched with start.
REQ-006 in_address  input  ADDR_WIDTH  start address; latched with start.
REQ-007 in_data  input  DATA_WIDTH  beat data; latched with start and on each accepted data_req.
REQ-008 in_burst  input  BURST_WIDTH  total beats; 0 or 1 means single beat.
REQ-009 slave_ready  input  1  slave idle indication.
REQ-010 tx_address, tx_data, tx_burst  output  1 each  serial lines, LSB first.
REQ-011 master_valid  output  1  transaction offered to slave.
REQ-012 read_en, write_en  output  1 each  transaction direction, held for whole transaction.
REQ-013 data_req  output  1  one-cycle pulse requesting next burst byte on in_data.
REQ-014 tx_busy  output  1  high in any state except IDLE.
REQ-015 tx_done  output  1  one-cycle completion pulse.

Function
REQ-016 States: IDLE, WAIT_HANDSHAKE, ADDR_SEND, BURST_GAP, DATA_SEND, DONE.
REQ-017 IDLE: start=1 latches all inputs into three shift registers and a 13-bit beat counter, enters WAIT_HANDSHAKE next cycle; start while tx_busy=1 is ignored.
REQ-018 WAIT_HANDSHAKE: master_valid=1, read_en/write_en per mode, bit 0 of each shift register driven on tx_*; held indefinitely until slave_ready=1.
REQ-019 Handshake cycle (master_valid & slave_ready) carries bit 0; master_valid drops the following cycle; state goes ADDR_SEND.
REQ-020 ADDR_SEND: one bit per cycle; address bits 1..11, burst bits 1..12, data bits 1..7 (write only); phase lasts 13 cycles including handshake; lines idle at 0 once a field is exhausted.
REQ-021 Read mode: tx_data=0 throughout.
REQ-022 After ADDR_SEND: if write, burst enabled and beat count >1, go BURST_GAP; else go DONE.
REQ-023 BURST_GAP: exactly one cycle; data_req=1; in_data latched at end of cycle; beat counter decremented.
REQ-024 DATA_SEND: 8 cycles, data bits 0..7 on tx_data; then BURST_GAP if beats remain, else DONE.
REQ-025 DONE: tx_done=1 for one cycle, read_en/write_en cleared, return to IDLE; start in DONE ignored.
REQ-026 Beat count 0 treated as 1; maximum 8191 beats, no wrap.

Reset
REQ-027 reset=0 asynchronously forces IDLE, clears shift registers and counters, drives every output 0.
REQ-028 Reset mid-transaction aborts without tx_done; first transaction after release starts cleanly.

Configuration
REQ-029 Macro MASTER_OUT_BURST_EN defined: multi-beat write bursts per REQ-022..024.
REQ-030 Macro undefined: in_burst ignored, tx_burst tied 0, data_req tied 0, every transaction single beat, BURST_GAP/DATA_SEND unreachable.

Structure
REQ-031 Shared package bus_pkg holds ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH defaults and the state encoding.
REQ-032 Sub-module piso_shift (load, shift, serial out, LSB first) instantiated once per serial line.

Verification
REQ-033 Write single: start, mode=1, addr=0xA5C, data=0x3B, burst=0, slave_ready=1 -> tx_address LSB-first 0xA5C over 12 cycles from handshake, tx_data 0x3B over 8, tx_done 13 cycles after handshake.
REQ-034 Read: mode=0, addr=0x123 -> read_en=1, write_en=0, tx_data stays 0, tx_done after 13 cycles.
REQ-035 Backpressure: slave_ready=0 for 5 cycles after start -> master_valid and bit 0 held stable, no progress until slave_ready=1.
REQ-036 Burst (macro on): burst=3, bytes 0x11,0x22,0x33 -> tx_burst serializes 3, two data_req pulses, three 8-bit data beats separated by one gap cycle, single tx_done.
REQ-037 Reset at cycle 6 of ADDR_SEND -> all outputs 0 immediately, no tx_done; new start afterwards completes normally.
REQ-038 Macro off, burst=3 -> single beat only, tx_burst=0, data_req never asserted.
